// File: rtl/ins_pkg.sv
// Shared encodings for the instruction fetch controller and accumulator/ALU block.
package ins_pkg;

  localparam int unsigned INS_W  = 16;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned ALU_W  = 3;

  localparam logic [OPC_W-1:0] OPC_CLA = 4'h0;
  localparam logic [OPC_W-1:0] OPC_COM = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SHR = 4'h2;
  localparam logic [OPC_W-1:0] OPC_CSL = 4'h3;
  localparam logic [OPC_W-1:0] OPC_STP = 4'h4;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'h5;
  localparam logic [OPC_W-1:0] OPC_STA = 4'h6;
  localparam logic [OPC_W-1:0] OPC_LDA = 4'h7;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'h8;
  localparam logic [OPC_W-1:0] OPC_BAN = 4'h9;

  typedef enum logic [ALU_W-1:0] {
    ALU_NOP = 3'd0,
    ALU_CLA = 3'd1,
    ALU_COM = 3'd2,
    ALU_SHR = 3'd3,
    ALU_CSL = 3'd4,
    ALU_ADD = 3'd5,
    ALU_LDA = 3'd6
  } aluop_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/ins_decoder.sv
// Opcode decoder: maps IR[15:12] to accumulator op, write enables and flow-control flags.
module ins_decoder
  import ins_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output aluop_e           o_alu_op,
  output logic             o_acc_we,
  output logic             o_mem_we,
  output logic             o_is_jmp,
  output logic             o_is_ban,
  output logic             o_is_stp
);

  always_comb begin
    o_alu_op = ALU_NOP;
    o_acc_we = 1'b0;
    o_mem_we = 1'b0;
    o_is_jmp = 1'b0;
    o_is_ban = 1'b0;
    o_is_stp = 1'b0;
    case (i_opcode)
      OPC_CLA: begin o_alu_op = ALU_CLA; o_acc_we = 1'b1; end
      OPC_COM: begin o_alu_op = ALU_COM; o_acc_we = 1'b1; end
      OPC_SHR: begin o_alu_op = ALU_SHR; o_acc_we = 1'b1; end
      OPC_CSL: begin o_alu_op = ALU_CSL; o_acc_we = 1'b1; end
      OPC_ADD: begin o_alu_op = ALU_ADD; o_acc_we = 1'b1; end
      OPC_LDA: begin o_alu_op = ALU_LDA; o_acc_we = 1'b1; end
      OPC_STA: o_mem_we = 1'b1;
      OPC_STP: o_is_stp = 1'b1;
      OPC_JMP: o_is_jmp = 1'b1;
      OPC_BAN: o_is_ban = 1'b1;
      default: ;  // 1010-1111 behave as NOP
    endcase
  end

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Two-cycle fetch/execute controller: owns PC, IR and the FETCH/EXEC/HALT state machine.
module ins_fetch_ctrl
  import ins_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INS_W-1:0]  ins,
  input  logic              accNeg,
  output logic [ADDR_W-1:0] insAd,
  output logic [ALU_W-1:0]  aluOp,
  output logic              accWe,
  output logic [ADDR_W-1:0] memAd,
  output logic              memWe,
  output logic              halted
);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]   r_cur_pc, w_cur_pc_nxt;
  logic [INS_W-1:0]    r_ir, w_ir_nxt;

  aluop_e              w_dec_alu_op;
  logic                w_dec_acc_we;
  logic                w_dec_mem_we;
  logic                w_dec_is_jmp;
  logic                w_dec_is_ban;
  logic                w_dec_is_stp;

  ins_decoder u_dec (
    .i_opcode (r_ir[INS_W-1:ADDR_W]),
    .o_alu_op (w_dec_alu_op),
    .o_acc_we (w_dec_acc_we),
    .o_mem_we (w_dec_mem_we),
    .o_is_jmp (w_dec_is_jmp),
    .o_is_ban (w_dec_is_ban),
    .o_is_stp (w_dec_is_stp)
  );

  // Enables come straight from the async-reset state, so they drop the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_cur_pc <= '0;
      r_ir     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_cur_pc <= w_cur_pc_nxt;
      r_ir     <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_cur_pc_nxt = r_cur_pc;
    w_ir_nxt     = r_ir;
    aluOp        = ALU_NOP;
    accWe        = 1'b0;
    memWe        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_ir_nxt     = ins;
        w_cur_pc_nxt = r_pc;
        w_pc_nxt     = r_pc + ADDR_W'(1);
        w_state_nxt  = ST_EXEC;
      end
      ST_EXEC: begin
        aluOp = w_dec_alu_op;
        accWe = w_dec_acc_we;
        memWe = w_dec_mem_we;
        if (w_dec_is_jmp) begin
          w_pc_nxt = r_ir[ADDR_W-1:0];
        end else if (w_dec_is_ban && accNeg) begin
          w_pc_nxt = r_cur_pc + r_ir[ADDR_W-1:0];
        end
        w_state_nxt = w_dec_is_stp ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  assign insAd  = r_pc;
  assign memAd  = r_ir[ADDR_W-1:0];
  assign halted = (r_state == ST_HALT);

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Scoreboard bench for ins_fetch_ctrl: expected per-cycle outputs are queued, then compared at negedge+1.
module tb_ins_fetch_ctrl;

  localparam logic [2:0] A_NOP = 3'd0;
  localparam logic [2:0] A_CLA = 3'd1;
  localparam logic [2:0] A_COM = 3'd2;
  localparam logic [2:0] A_SHR = 3'd3;
  localparam logic [2:0] A_CSL = 3'd4;
  localparam logic [2:0] A_ADD = 3'd5;
  localparam logic [2:0] A_LDA = 3'd6;

  typedef struct packed {
    logic [11:0] ins_ad;
    logic [2:0]  alu_op;
    logic        acc_we;
    logic        mem_we;
    logic [11:0] mem_ad;
    logic        halted;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ins;
  logic        accNeg = 1'b0;
  logic [11:0] insAd;
  logic [2:0]  aluOp;
  logic        accWe;
  logic [11:0] memAd;
  logic        memWe;
  logic        halted;

  logic [15:0] imem [0:4095];
  obs_t        w_obs;
  obs_t        exp_q [$];
  string       tag_q [$];
  obs_t        e;
  string       t;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [15:0] ops_prog [9];
  logic [2:0]  ops_alu  [9];
  logic        ops_acc  [9];
  logic        ops_mem  [9];

  ins_fetch_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ins    (ins),
    .accNeg (accNeg),
    .insAd  (insAd),
    .aluOp  (aluOp),
    .accWe  (accWe),
    .memAd  (memAd),
    .memWe  (memWe),
    .halted (halted)
  );

  always #5 clk = ~clk;
  assign ins   = imem[insAd];
  assign w_obs = {insAd, aluOp, accWe, memWe, memAd, halted};

  task automatic push_exp(input string tag, input logic [11:0] ia, input logic [2:0] op,
                          input logic aw, input logic mw, input logic [11:0] ma, input logic h);
    obs_t o;
    o = {ia, op, aw, mw, ma, h};
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
  endtask

  // Hold reset two cycles, release just after a negedge so the next posedge fetches from 0.
  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    fill_nop();
    imem[0] = 16'h7ABC;
    rst_n = 1'b0;
    @(negedge clk); #1;
    push_exp("reset_hold", 12'h000, A_NOP, 0, 0, 12'h000, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    push_exp("reset_hold_clocked", 12'h000, A_NOP, 0, 0, 12'h000, 0);
    rst_n = 1'b1;
    push_exp("rel_fetch0", 12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("rel_exec_lda", 12'h001, A_LDA, 1, 0, 12'hABC, 0);
    // first two entries were observed while rst_n was still low
    e = exp_q.pop_front(); t = tag_q.pop_front();
    n_checks++;
    if (12'h000 !== insAd || A_NOP !== aluOp || accWe !== 1'b0 || memWe !== 1'b0 || halted !== 1'b0)
      $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b h=%b", t, insAd, aluOp, accWe, memWe, halted);
    else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      if (exp_q.size() != 0 && t != "reset_hold_clocked") begin @(negedge clk); #1; end
      else if (t == "rel_exec_lda") begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_lda();
    fill_nop();
    imem[0] = 16'h7000;
    imem[1] = 16'h0000;
    apply_reset();
    push_exp("lda_c1_fetch", 12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("lda_c2_exec",  12'h001, A_LDA, 1, 0, 12'h000, 0);
    push_exp("lda_c3_fetch", 12'h001, A_NOP, 0, 0, 12'h000, 0);
    push_exp("cla_exec",     12'h002, A_CLA, 1, 0, 12'h000, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_ops();
    fill_nop();
    ops_prog = '{16'h0011, 16'h1022, 16'h2033, 16'h3044, 16'h5055, 16'h6066, 16'h7077, 16'hA088, 16'hF099};
    ops_alu  = '{A_CLA, A_COM, A_SHR, A_CSL, A_ADD, A_NOP, A_LDA, A_NOP, A_NOP};
    ops_acc  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ops_mem  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 9; k++) imem[k] = ops_prog[k];
    accNeg = 1'b1;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      push_exp($sformatf("ops_fetch%0d", k), 12'(k), A_NOP, 0, 0,
               (k == 0) ? 12'h000 : ops_prog[k-1][11:0], 0);
      push_exp($sformatf("ops_exec%0d", k), 12'(k + 1), ops_alu[k], ops_acc[k], ops_mem[k],
               ops_prog[k][11:0], 0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_branch();
    fill_nop();
    imem[0]  = 16'h8005;  // JMP 5
    imem[5]  = 16'h9002;  // BAN +2, taken
    imem[7]  = 16'h8009;  // JMP 9
    imem[9]  = 16'h5001;  // ADD 1
    imem[10] = 16'h8002;  // JMP 2
    imem[2]  = 16'h900A;  // BAN +10, not taken
    imem[3]  = 16'h1ABC;  // COM
    accNeg = 1'b1;
    apply_reset();
    push_exp("br_f0",      12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("br_jmp5",    12'h001, A_NOP, 0, 0, 12'h005, 0);
    push_exp("br_f5",      12'h005, A_NOP, 0, 0, 12'h005, 0);
    push_exp("br_ban_neg", 12'h006, A_NOP, 0, 0, 12'h002, 0);
    push_exp("br_taken7",  12'h007, A_NOP, 0, 0, 12'h002, 0);
    push_exp("br_jmp9",    12'h008, A_NOP, 0, 0, 12'h009, 0);
    push_exp("br_f9",      12'h009, A_NOP, 0, 0, 12'h009, 0);
    push_exp("br_add",     12'h00A, A_ADD, 1, 0, 12'h001, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
    accNeg = 1'b0;
    push_exp("br_f10",     12'h00A, A_NOP, 0, 0, 12'h001, 0);
    push_exp("br_jmp2",    12'h00B, A_NOP, 0, 0, 12'h002, 0);
    push_exp("br_f2",      12'h002, A_NOP, 0, 0, 12'h002, 0);
    push_exp("br_ban_pos", 12'h003, A_NOP, 0, 0, 12'h00A, 0);
    push_exp("br_fall3",   12'h003, A_NOP, 0, 0, 12'h00A, 0);
    push_exp("br_com",     12'h004, A_COM, 1, 0, 12'hABC, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    fill_nop();
    imem[0]    = 16'h8FFF;  // JMP 4095
    imem[4095] = 16'hF123;  // NOP opcode at the top of the address space
    apply_reset();
    push_exp("wr_f0",     12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("wr_jmp",    12'h001, A_NOP, 0, 0, 12'hFFF, 0);
    push_exp("wr_f4095",  12'hFFF, A_NOP, 0, 0, 12'hFFF, 0);
    push_exp("wr_nop_ex", 12'h000, A_NOP, 0, 0, 12'h123, 0);
    push_exp("wr_f0b",    12'h000, A_NOP, 0, 0, 12'h123, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_halt();
    fill_nop();
    imem[0]  = 16'h800D;  // JMP 13
    imem[13] = 16'h4000;  // STP
    imem[14] = 16'h6005;  // STA must never execute
    apply_reset();
    push_exp("ht_f0",   12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("ht_jmp",  12'h001, A_NOP, 0, 0, 12'h00D, 0);
    push_exp("ht_f13",  12'h00D, A_NOP, 0, 0, 12'h00D, 0);
    push_exp("ht_stp",  12'h00E, A_NOP, 0, 0, 12'h000, 0);
    for (int i = 0; i < 21; i++)
      push_exp($sformatf("ht_sticky%0d", i), 12'h00E, A_NOP, 0, 0, 12'h000, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== {12'h000, A_NOP, 1'b0, 1'b0, 12'h000, 1'b0})
      $display("FAIL ht_reset_pulse: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want all zero",
               insAd, aluOp, accWe, memWe, memAd, halted);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push_exp("ht_rel_f0",  12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("ht_rel_jmp", 12'h001, A_NOP, 0, 0, 12'h00D, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sta();
    fill_nop();
    imem[0] = 16'h6033;  // STA 0x033
    apply_reset();
    push_exp("mr_f0",  12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("mr_sta", 12'h001, A_NOP, 0, 1, 12'h033, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
    // still inside the STA EXEC cycle: reset must drop memWe without waiting for a clock
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== {12'h000, A_NOP, 1'b0, 1'b0, 12'h000, 1'b0})
      $display("FAIL mr_async_drop: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want all zero",
               insAd, aluOp, accWe, memWe, memAd, halted);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push_exp("mr_rel_f0",  12'h000, A_NOP, 0, 0, 12'h000, 0);
    push_exp("mr_rel_sta", 12'h001, A_NOP, 0, 1, 12'h033, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      n_checks++;
      if (w_obs !== e)
        $display("FAIL %s: got ia=%h op=%0d acc=%b mem=%b ma=%h h=%b, want ia=%h op=%0d acc=%b mem=%b ma=%h h=%b",
                 t, w_obs.ins_ad, w_obs.alu_op, w_obs.acc_we, w_obs.mem_we, w_obs.mem_ad, w_obs.halted,
                 e.ins_ad, e.alu_op, e.acc_we, e.mem_we, e.mem_ad, e.halted);
      else n_pass++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_ops();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid_sta();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
